fpu_result_buffer: RTL

FPU_RESULT_BUFFER -- requirements
Module: fpu_result_buffer

---
 rtl/fpu_result_buffer_if.sv | 30 +++
 rtl/fpu_result_buffer.sv | 75 +++++++
 2 files changed

// File: rtl/fpu_result_buffer_if.sv
// Handshake bundle between float_alu, the result buffer and the downstream consumer.
// The slave modport is the buffer's view; master is the environment driving it.
interface fpu_result_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             alu_valid;
    logic [31:0]      alu_result;
    logic [4:0]       alu_flags;
    logic             alu_ready;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [4:0]       out_flags;
    logic             sticky_clr;
    logic [4:0]       sticky_flags;
    logic [CNT_W-1:0] count;
    logic [15:0]      retire_cnt;

    modport slave (
        input  alu_valid, alu_result, alu_flags, out_ready, sticky_clr,
        output alu_ready, out_valid, out_result, out_flags, sticky_flags, count, retire_cnt
    );

    modport master (
        output alu_valid, alu_result, alu_flags, out_ready, sticky_clr,
        input  alu_ready, out_valid, out_result, out_flags, sticky_flags, count, retire_cnt
    );
endinterface

// File: rtl/fpu_result_buffer.sv
// First-word fall-through FIFO for float_alu results, with sticky exception
// flag accumulation and a count of retired entries.
module fpu_result_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fpu_result_buffer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [36:0]      mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [4:0]       sticky_flags;
    logic [15:0]      retire_cnt;
    logic [36:0]      head_entry;

    logic not_full;
    logic not_empty;
    logic push;
    logic pop;

    // Ready/valid come only from registered occupancy, so a full buffer never
    // accepts in the same cycle it frees a slot.
    assign not_full  = (count != FULL_COUNT);
    assign not_empty = (count != '0);
    assign push      = bus.alu_valid && not_full;
    assign pop       = bus.out_ready && not_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= {bus.alu_result, bus.alu_flags};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            sticky_flags <= '0;
            retire_cnt   <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head       <= head + PTR_W'(1);
                retire_cnt <= retire_cnt + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Clear takes effect before this cycle's flags are accumulated.
            sticky_flags <= (bus.sticky_clr ? 5'b0 : sticky_flags)
                          | (push ? bus.alu_flags : 5'b0);
        end
    end

    // Masking with occupancy keeps stale or never-written slots off the outputs.
    assign head_entry       = mem[head];
    assign bus.out_valid    = not_empty;
    assign bus.out_result   = not_empty ? head_entry[36:5] : 32'b0;
    assign bus.out_flags    = not_empty ? head_entry[4:0]  : 5'b0;
    assign bus.alu_ready    = not_full;
    assign bus.count        = count;
    assign bus.sticky_flags = sticky_flags;
    assign bus.retire_cnt   = retire_cnt;
endmodule
